// File: rtl/frame_sequencer.sv
// frame_sequencer
// Generates the modulo-PERIOD frame counter (count40) consumed by the
// test-mode FSM and schedules runs of a programmed number of frames, or a
// free run that ends only on a graceful stop request.
//
// Ports:
//   clk          in   rising-edge clock
//   rst          in   synchronous active-high reset
//   start_req    in   level start request, held until start_ack
//   frames_i     in   frames to run (0 = free-run), sampled with the start
//   stop_req     in   graceful stop, honoured only while running
//   start_ack    out  one-cycle pulse, start accepted
//   count_o      out  frame counter 0..PERIOD-1
//   count_valid  out  count_o is live
//   frame_start  out  count_o == 0 while live
//   frame_end    out  count_o == PERIOD-1 while live
//   last_frame   out  the current frame is the final one
//   busy         out  a run is in progress
//   done         out  one-cycle pulse after a completed run
//   frames_done  out  frames completed since the last start
//
// Every output is a register loaded from the matching w_*_nxt value.

module frame_sequencer #(
  parameter int PERIOD   = 40,
  parameter int CNT_W    = 6,
  parameter int FRAMES_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_req,
  input  logic [FRAMES_W-1:0] frames_i,
  input  logic                stop_req,
  output logic                start_ack,
  output logic [CNT_W-1:0]    count_o,
  output logic                count_valid,
  output logic                frame_start,
  output logic                frame_end,
  output logic                last_frame,
  output logic                busy,
  output logic                done,
  output logic [FRAMES_W-1:0] frames_done
);

  if ((PERIOD < 2) || (PERIOD > (2 ** CNT_W))) begin : g_period_check
    $error("frame_sequencer: PERIOD must lie in 2 .. 2**CNT_W");
  end

  localparam logic [CNT_W-1:0]    LAST_CNT = CNT_W'(PERIOD - 1);
  localparam logic [FRAMES_W-1:0] ONE_FRM  = FRAMES_W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_STOP = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [FRAMES_W-1:0] r_frames_left;
  logic [FRAMES_W-1:0] w_frames_left_nxt;
  logic [FRAMES_W-1:0] w_frames_dec;

  logic                w_start_ack_nxt;
  logic [CNT_W-1:0]    w_count_nxt;
  logic                w_valid_nxt;
  logic                w_fstart_nxt;
  logic                w_fend_nxt;
  logic                w_last_nxt;
  logic                w_busy_nxt;
  logic                w_done_nxt;
  logic [FRAMES_W-1:0] w_frames_done_nxt;

  logic                w_wrap;
  logic [CNT_W-1:0]    w_cnt_inc;

  // Counter wrap detection and the counter's successor value.
  always_comb begin
    w_wrap       = (count_o == LAST_CNT);
    w_cnt_inc    = w_wrap ? {CNT_W{1'b0}} : (count_o + CNT_W'(1));
    w_frames_dec = r_frames_left - ONE_FRM;
  end

  // Next-state and next-output decode; every output is recomputed each cycle.
  always_comb begin
    w_state_nxt       = r_state;
    w_frames_left_nxt = r_frames_left;
    w_start_ack_nxt   = 1'b0;
    w_count_nxt       = {CNT_W{1'b0}};
    w_valid_nxt       = 1'b0;
    w_fstart_nxt      = 1'b0;
    w_fend_nxt        = 1'b0;
    w_last_nxt        = 1'b0;
    w_busy_nxt        = 1'b0;
    w_done_nxt        = 1'b0;
    w_frames_done_nxt = frames_done;

    case (r_state)
      S_IDLE: begin
        // A start wins over any concurrent stop, which is simply dropped.
        if (start_req) begin
          w_start_ack_nxt   = 1'b1;
          w_frames_left_nxt = frames_i;
          w_frames_done_nxt = {FRAMES_W{1'b0}};
          w_valid_nxt       = 1'b1;
          w_busy_nxt        = 1'b1;
          w_fstart_nxt      = 1'b1;
          if (frames_i == ONE_FRM) begin
            w_state_nxt = S_STOP;
            w_last_nxt  = 1'b1;
          end else begin
            w_state_nxt = S_RUN;
            w_last_nxt  = 1'b0;
          end
        end else begin
          w_state_nxt = S_IDLE;
        end
      end

      S_RUN: begin
        w_count_nxt  = w_cnt_inc;
        w_valid_nxt  = 1'b1;
        w_busy_nxt   = 1'b1;
        w_fstart_nxt = (w_cnt_inc == {CNT_W{1'b0}});
        w_fend_nxt   = (w_cnt_inc == LAST_CNT);
        if (w_wrap) begin
          w_frames_done_nxt = frames_done + ONE_FRM;
        end else begin
          w_frames_done_nxt = frames_done;
        end

        if (stop_req && w_wrap) begin
          // Stop landing on frame_end: the ending frame is the last one.
          w_state_nxt  = S_IDLE;
          w_done_nxt   = 1'b1;
          w_count_nxt  = {CNT_W{1'b0}};
          w_valid_nxt  = 1'b0;
          w_busy_nxt   = 1'b0;
          w_fstart_nxt = 1'b0;
          w_fend_nxt   = 1'b0;
        end else if (stop_req) begin
          w_state_nxt = S_STOP;
          w_last_nxt  = 1'b1;
        end else if (w_wrap && (r_frames_left != {FRAMES_W{1'b0}})) begin
          // Counted run; frames_left stays 0 throughout a free run.
          w_frames_left_nxt = w_frames_dec;
          if (w_frames_dec == ONE_FRM) begin
            w_state_nxt = S_STOP;
            w_last_nxt  = 1'b1;
          end else begin
            w_state_nxt = S_RUN;
          end
        end else begin
          w_state_nxt = S_RUN;
        end
      end

      S_STOP: begin
        if (w_wrap) begin
          w_state_nxt       = S_IDLE;
          w_done_nxt        = 1'b1;
          w_frames_done_nxt = frames_done + ONE_FRM;
        end else begin
          w_state_nxt  = S_STOP;
          w_count_nxt  = w_cnt_inc;
          w_valid_nxt  = 1'b1;
          w_busy_nxt   = 1'b1;
          w_last_nxt   = 1'b1;
          w_fstart_nxt = (w_cnt_inc == {CNT_W{1'b0}});
          w_fend_nxt   = (w_cnt_inc == LAST_CNT);
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State, frame bookkeeping and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_frames_left <= {FRAMES_W{1'b0}};
      start_ack     <= 1'b0;
      count_o       <= {CNT_W{1'b0}};
      count_valid   <= 1'b0;
      frame_start   <= 1'b0;
      frame_end     <= 1'b0;
      last_frame    <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      frames_done   <= {FRAMES_W{1'b0}};
    end else begin
      r_state       <= w_state_nxt;
      r_frames_left <= w_frames_left_nxt;
      start_ack     <= w_start_ack_nxt;
      count_o       <= w_count_nxt;
      count_valid   <= w_valid_nxt;
      frame_start   <= w_fstart_nxt;
      frame_end     <= w_fend_nxt;
      last_frame    <= w_last_nxt;
      busy          <= w_busy_nxt;
      done          <= w_done_nxt;
      frames_done   <= w_frames_done_nxt;
    end
  end

endmodule
